// File: rtl/fir_coef_ctrl_if.sv
// Host-side coefficient stream: valid/ready handshake carrying one FIR
// coefficient per beat, with a last flag closing each set.
interface fir_coef_ctrl_if #(
  parameter int COEF_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Sequences the ADC-path FIR: loads and validates a coefficient set, enables
// the filter, and keeps the output mux on raw data until the pipeline settles.
module fir_coef_ctrl #(
  parameter int TAPS       = 16,
  parameter int COEF_W     = 16,
  parameter int SETTLE_CYC = 24,
  localparam int AW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              ad_clk,
  input  logic              rst,
  input  logic              fir_en_req,
  fir_coef_ctrl_if.slave    cfg,
  output logic              coef_we,
  output logic [AW-1:0]     coef_addr,
  output logic [COEF_W-1:0] coef_wdata,
  output logic              fir_en,
  output logic              out_sel,
  output logic              coef_loaded,
  output logic              load_err,
  output logic              busy
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW-1:0] LAST_IDX   = AW'(TAPS - 1);
  localparam logic [CW-1:0] SETTLE_INI = CW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DISCARD, SETTLE, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   beat_idx;
  logic [CW-1:0]   settle_cnt;
  logic [AW-1:0]   cur_idx;
  logic            accept;

  assign cfg.cfg_ready = ~rst & ((state == IDLE) | (state == LOAD) | (state == DISCARD));
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  // The first beat of a set (taken in IDLE) is index 0 and follows the LOAD rules.
  always_comb begin
    cur_idx = beat_idx;
    if (state == IDLE) cur_idx = '0;
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_idx    <= '0;
      settle_cnt  <= '0;
      coef_we     <= 1'b0;
      coef_addr   <= '0;
      coef_wdata  <= '0;
      fir_en      <= 1'b0;
      out_sel     <= 1'b0;
      coef_loaded <= 1'b0;
      load_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coef_we <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            coef_we    <= 1'b1;
            coef_addr  <= cur_idx;
            coef_wdata <= cfg.cfg_data;
            if (state == IDLE) begin
              coef_loaded <= 1'b0;
              load_err    <= 1'b0;
            end
            if (cfg.cfg_last && cur_idx == LAST_IDX) begin
              state       <= IDLE;
              busy        <= 1'b0;
              coef_loaded <= 1'b1;
            end else if (cfg.cfg_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              load_err <= 1'b1;
            end else if (cur_idx == LAST_IDX) begin
              state    <= DISCARD;
              busy     <= 1'b1;
              load_err <= 1'b1;
            end else begin
              state    <= LOAD;
              busy     <= 1'b1;
              beat_idx <= cur_idx + AW'(1);
            end
          end else if (state == IDLE && fir_en_req && coef_loaded) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            fir_en     <= 1'b1;
            settle_cnt <= SETTLE_INI;
          end
        end
        DISCARD: begin
          if (accept && cfg.cfg_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETTLE, RUN: begin
          // Dropping the switch wins so no filtered sample leaks out afterwards.
          if (!fir_en_req) begin
            state   <= IDLE;
            busy    <= 1'b0;
            fir_en  <= 1'b0;
            out_sel <= 1'b0;
          end else if (state == SETTLE) begin
            if (settle_cnt == '0) begin
              state   <= RUN;
              busy    <= 1'b0;
              out_sel <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Bench for fir_coef_ctrl: drives coefficient sets and the filter switch,
// scoreboarding every coefficient write against an expected queue.
module tb_fir_coef_ctrl;

  localparam int TAPS       = 16;
  localparam int COEF_W     = 16;
  localparam int SETTLE_CYC = 24;
  localparam int AW         = $clog2(TAPS);

  logic              ad_clk = 1'b0;
  logic              rst;
  logic              fir_en_req;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              fir_en;
  logic              out_sel;
  logic              coef_loaded;
  logic              load_err;
  logic              busy;

  fir_coef_ctrl_if #(.COEF_W(COEF_W)) cfg_if ();

  fir_coef_ctrl #(.TAPS(TAPS), .COEF_W(COEF_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .ad_clk      (ad_clk),
    .rst         (rst),
    .fir_en_req  (fir_en_req),
    .cfg         (cfg_if.slave),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .fir_en      (fir_en),
    .out_sel     (out_sel),
    .coef_loaded (coef_loaded),
    .load_err    (load_err),
    .busy        (busy)
  );

  always #5 ad_clk = ~ad_clk;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [COEF_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   writes_seen = 0;
  int   first_we_cyc = 0;
  int   last_we_cyc = 0;

  always @(posedge ad_clk) cyc <= cyc + 1;

  // Every write strobe must match the oldest expected write, including its cycle.
  always @(negedge ad_clk) begin
    if (coef_we === 1'b1) begin
      writes_seen++;
      if (writes_seen == 1) first_we_cyc = cyc;
      last_we_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write addr=%0d data=%h cyc=%0d", coef_addr, coef_wdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (coef_addr !== e.addr || coef_wdata !== e.data || cyc !== e.cyc) begin
          failures++;
          $display("[TB] FAIL write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                   coef_addr, coef_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge ad_clk);
    #1;
  endtask

  task automatic expect_bit(string name, logic actual, logic required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b", name, actual, required);
    end
  endtask

  task automatic expect_int(string name, int actual, int required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, required);
    end
  endtask

  // Sends n beats; beats beyond TAPS are expected to be swallowed without a write.
  task automatic send_set(int n, logic [COEF_W-1:0] base, bit gaps);
    int wait_cnt;
    writes_seen = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = base + COEF_W'(k);
      cfg_if.cfg_last  = (k == n - 1);
      wait_cnt = 0;
      while (cfg_if.cfg_ready !== 1'b1 && wait_cnt < 50) begin
        step();
        wait_cnt++;
      end
      if (cfg_if.cfg_ready !== 1'b1) begin
        checks++;
        failures++;
        $display("[TB] FAIL ready_timeout beat=%0d got=%b expected=1", k, cfg_if.cfg_ready);
        cfg_if.cfg_valid = 1'b0;
        return;
      end
      step();
      if (k < TAPS) exp_q.push_back('{addr: AW'(k), data: base + COEF_W'(k), cyc: cyc});
      if (k == 0 && n > 1) expect_bit("busy_during_load", busy, 1'b1);
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_last  = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fir_en_req = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_last  = 1'b0;
    repeat (2) step();
    expect_bit("reset_cfg_ready", cfg_if.cfg_ready, 1'b0);
    expect_bit("reset_coef_we", coef_we, 1'b0);
    expect_bit("reset_fir_en", fir_en, 1'b0);
    expect_bit("reset_out_sel", out_sel, 1'b0);
    expect_bit("reset_coef_loaded", coef_loaded, 1'b0);
    expect_bit("reset_load_err", load_err, 1'b0);
    expect_bit("reset_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    expect_bit("idle_cfg_ready", cfg_if.cfg_ready, 1'b1);
  endtask

  task automatic test_good_load(bit gaps, logic [COEF_W-1:0] base);
    send_set(TAPS, base, gaps);
    expect_int("good_writes", writes_seen, TAPS);
    expect_int("good_queue_left", exp_q.size(), 0);
    if (!gaps) expect_int("good_consecutive_span", last_we_cyc - first_we_cyc, TAPS - 1);
    expect_bit("good_coef_loaded", coef_loaded, 1'b1);
    expect_bit("good_load_err", load_err, 1'b0);
    expect_bit("good_busy_end", busy, 1'b0);
  endtask

  task automatic test_enable();
    int n;
    fir_en_req = 1'b1;
    step();
    expect_bit("settle_fir_en", fir_en, 1'b1);
    expect_bit("settle_out_sel", out_sel, 1'b0);
    expect_bit("settle_busy", busy, 1'b1);
    expect_bit("settle_cfg_ready", cfg_if.cfg_ready, 1'b0);
    n = 0;
    while (out_sel !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    expect_int("settle_latency", n, SETTLE_CYC);
    expect_bit("run_fir_en", fir_en, 1'b1);
    expect_bit("run_busy", busy, 1'b0);
    // Host pushes beats while running: they must be refused and never written.
    writes_seen = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 16'hDEAD;
    repeat (4) begin
      expect_bit("run_cfg_ready", cfg_if.cfg_ready, 1'b0);
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    step();
    expect_int("run_no_writes", writes_seen, 0);
    fir_en_req = 1'b0;
    step();
    expect_bit("exit_fir_en", fir_en, 1'b0);
    expect_bit("exit_out_sel", out_sel, 1'b0);
    expect_bit("exit_cfg_ready", cfg_if.cfg_ready, 1'b1);
  endtask

  task automatic test_short_set();
    bit en_seen;
    send_set(5, 16'h0200, 1'b0);
    expect_int("short_writes", writes_seen, 5);
    expect_int("short_queue_left", exp_q.size(), 0);
    expect_bit("short_load_err", load_err, 1'b1);
    expect_bit("short_coef_loaded", coef_loaded, 1'b0);
    fir_en_req = 1'b1;
    en_seen = 1'b0;
    repeat (6) begin
      step();
      if (fir_en !== 1'b0) en_seen = 1'b1;
    end
    expect_bit("short_fir_en_blocked", en_seen, 1'b0);
    fir_en_req = 1'b0;
    step();
  endtask

  task automatic test_long_set();
    send_set(20, 16'h0300, 1'b0);
    expect_int("long_writes", writes_seen, TAPS);
    expect_int("long_queue_left", exp_q.size(), 0);
    expect_bit("long_load_err", load_err, 1'b1);
    expect_bit("long_coef_loaded", coef_loaded, 1'b0);
    expect_bit("long_busy", busy, 1'b0);
    expect_bit("long_cfg_ready", cfg_if.cfg_ready, 1'b1);
  endtask

  task automatic test_reset_in_settle();
    bit en_seen;
    send_set(3, 16'h0500, 1'b0);
    test_good_load(1'b0, 16'h0600);
    fir_en_req = 1'b1;
    repeat (5) step();
    expect_bit("pre_rst_fir_en", fir_en, 1'b1);
    rst = 1'b1;
    #1;
    expect_bit("rst_cfg_ready", cfg_if.cfg_ready, 1'b0);
    step();
    rst = 1'b0;
    expect_bit("rst_fir_en", fir_en, 1'b0);
    expect_bit("rst_out_sel", out_sel, 1'b0);
    expect_bit("rst_coef_loaded", coef_loaded, 1'b0);
    expect_bit("rst_load_err", load_err, 1'b0);
    en_seen = 1'b0;
    repeat (10) begin
      step();
      if (fir_en !== 1'b0) en_seen = 1'b1;
    end
    expect_bit("rst_req_ignored", en_seen, 1'b0);
    fir_en_req = 1'b0;
    step();
    test_good_load(1'b0, 16'h0700);
  endtask

  initial begin
    test_reset();
    test_good_load(1'b0, 16'h0100);
    test_enable();
    test_short_set();
    test_long_set();
    test_good_load(1'b1, 16'h0400);
    test_reset_in_settle();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Controller that sequences the ADC-path FIR low-pass filter.
- Accepts a coefficient stream from the host over a valid/ready handshake, writes it into the FIR coefficient port, and validates the tap count.
- Enables the filter only when a complete coefficient set is loaded, then holds the output mux on raw ADC data until the filter pipeline has settled.
- Sits between the host config logic and the FIR core/output mux in the ad_clk domain.

Parameters:
- TAPS, 16: number of FIR coefficients; coef_addr width AW = clog2(TAPS), derived internally.
- COEF_W, 16: coefficient width.
- SETTLE_CYC, 24: cycles from fir_en rising to first trustworthy filtered sample (FIR latency + TAPS); must be >= 1.

Ports:
- ad_clk  in  1  ADC sample clock; sole clock.
- rst  in  1  reset, synchronous, active-high.
- fir_en_req  in  1  user filter switch (level).
- cfg_valid  in  1  coefficient beat valid.
- cfg_ready  out  1  coefficient beat ready.
- cfg_data  in  COEF_W  coefficient value.
- cfg_last  in  1  marks final beat of a set.
- coef_we  out  1  coefficient write strobe to FIR.
- coef_addr  out  AW  coefficient index.
- coef_wdata  out  COEF_W  coefficient value.
- fir_en  out  1  FIR enable.
- out_sel  out  1  output mux select: 1 = filtered, 0 = raw ADC.
- coef_loaded  out  1  a valid full set is resident.
- load_err  out  1  sticky tap-count error.
- busy  out  1  state != IDLE and != RUN.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, all registered outputs 0, internal beat counter 0, coef_loaded=0, load_err=0. cfg_ready=0 while rst=1.
- cfg_ready is 1 iff ~rst and state in {IDLE, LOAD, DISCARD}. A beat is accepted when cfg_valid & cfg_ready.
- All other outputs are registered.
- States: IDLE, LOAD, DISCARD, SETTLE, RUN.
- IDLE:
  - fir_en=0, out_sel=0.
  - An accepted beat writes at addr 0, clears coef_loaded, and goes to LOAD (or returns to IDLE if cfg_last and TAPS==1).
  - Else, if fir_en_req & coef_loaded: go to SETTLE and load the settle counter with SETTLE_CYC-1.
  - An accepted beat has priority over fir_en_req in the same cycle.
- Write timing:
  - Every accepted beat in IDLE/LOAD produces coef_we=1 for exactly one cycle on the next edge, with coef_addr=beat index and coef_wdata=cfg_data.
  - coef_we is 0 otherwise; coef_addr/coef_wdata hold their last values.
- LOAD, beat index k:
  - cfg_last & k==TAPS-1: IDLE, coef_loaded=1, load_err unchanged.
  - cfg_last & k<TAPS-1: IDLE, coef_loaded=0, load_err=1.
  - ~cfg_last & k==TAPS-1: the beat is written, then go to DISCARD with load_err=1.
  - Otherwise stay in LOAD and increment the index.
- DISCARD: accept beats without writing; the beat with cfg_last returns to IDLE with coef_loaded=0.
- Gaps: cfg_valid=0 gaps are allowed in LOAD/DISCARD with no timeout.
- load_err clears only on rst or on the first accepted beat of a new set (the IDLE->LOAD transition).
- SETTLE:
  - fir_en=1, out_sel=0; counter decrements each cycle.
  - On the cycle the counter is 0, go to RUN and set out_sel=1.
  - Result: out_sel rises exactly SETTLE_CYC cycles after fir_en rises.
- RUN: fir_en=1, out_sel=1.
- Exit from SETTLE/RUN: fir_en_req=0 returns to IDLE next edge, with fir_en=0 and out_sel=0 on the same edge (no filtered sample after the switch drops).
- cfg_ready=0 in SETTLE/RUN; the host must drop fir_en_req before reloading.
- busy=1 in LOAD, DISCARD, SETTLE.
- rst asserted mid-LOAD/SETTLE/RUN: full return to reset values, including coef_loaded=0 (coefficient RAM content is treated as invalid).

Test Plan:
- Reset, TAPS=16: stream 16 beats (0x0100..0x010F, last on 16th, continuous valid) -> coef_we pulses on 16 consecutive cycles, addr 0..15 each one cycle after its beat; coef_loaded=1, load_err=0, busy 1->0.
- After a good load, fir_en_req=1 at cycle T -> fir_en=1 at T+1, out_sel=1 at T+1+24; drop fir_en_req -> fir_en and out_sel both 0 on the following edge.
- Short set: 5 beats with cfg_last on 5th -> 5 writes, load_err=1, coef_loaded=0; fir_en_req=1 afterward -> fir_en stays 0.
- Long set: 20 beats, last on 20th -> exactly 16 writes (addr 0..15), beats 17..20 accepted with no coef_we, load_err=1, coef_loaded=0, ends in IDLE with cfg_ready=1.
- In RUN, cfg_valid=1 held -> cfg_ready=0, no coef_we; random cfg_valid gaps during a 16-beat load -> same writes as the continuous case.
- rst=1 for one cycle during SETTLE -> next cycle fir_en=0, out_sel=0, coef_loaded=0, load_err=0; fir_en_req=1 is ignored until a new full set is loaded.
